// File: rtl/dac121s101_pkg.sv
// Shared constants and helpers for the DAC121S101 write-side SPI master.
package dac121s101_pkg;

   localparam int FRAME_BITS  = 16;

   localparam logic [1:0] PD_NORMAL = 2'b00;
   localparam logic [1:0] PD_1K     = 2'b01;
   localparam logic [1:0] PD_100K   = 2'b10;
   localparam logic [1:0] PD_HIZ    = 2'b11;

   localparam int T_SU_NS     = 10;
   localparam int T_QUIET_NS  = 20;
   localparam int SCLK_MAX_HZ = 30000000;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETUP,
      ST_SHIFT,
      ST_QUIET
   } state_t;

   // Whole clock cycles covering ns nanoseconds, never less than one.
   function automatic int ns_to_cycles(input longint clk_hz, input longint ns);
      longint c;
      c = (clk_hz * ns + 64'sd999999999) / 64'sd1000000000;
      return (c < 1) ? 1 : int'(c);
   endfunction

endpackage

// File: rtl/dac121s101_interface_timer.sv
// Loadable down-counter; o_zero is high once the loaded count has elapsed.
module dac121s101_interface_timer #(
   parameter int W = 4
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_load,
   input  logic [W-1:0] i_val,
   output logic         o_zero
);

   logic [W-1:0] r_cnt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         r_cnt <= '0;
      else if (i_load)
         r_cnt <= i_val;
      else if (r_cnt != '0)
         r_cnt <= r_cnt - 1'b1;
   end

   assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/dac121s101_interface.sv
// SPI master writing {00, PD1:PD0, sample} frames to a DAC121S101; SCLK idles
// high and the DAC samples DIN on each falling edge while SYNC is low.
module dac121s101_interface
   import dac121s101_pkg::*;
#(
   parameter int CLK_FREQ_HZ  = 100000000,
   parameter int SCLK_FREQ_HZ = 20000000
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic [11:0] data_i,
   input  logic [1:0]  mode_i,
   input  logic        valid_i,
   output logic        ready_o,
   output logic        done_o,
   output logic        sclk_o,
   output logic        sync_n_o,
   output logic        din_o
);

   localparam int CLK_DIV = CLK_FREQ_HZ / SCLK_FREQ_HZ;
   localparam int HIGH_PH = CLK_DIV / 2;
   localparam int T_SU    = ns_to_cycles(longint'(CLK_FREQ_HZ), longint'(T_SU_NS));
   localparam int T_QUIET = ns_to_cycles(longint'(CLK_FREQ_HZ), longint'(T_QUIET_NS));
   localparam int TMR_MAX = (T_SU > T_QUIET) ? T_SU : T_QUIET;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);
   localparam int PH_W    = $clog2(CLK_DIV);

   generate
      if (SCLK_FREQ_HZ > SCLK_MAX_HZ || CLK_DIV < 2) begin : g_bad_cfg
         $error("dac121s101_interface: SCLK_FREQ_HZ too high for DAC or clock");
      end
   endgenerate

   state_t            r_state, w_state;
   logic [PH_W-1:0]   r_ph, w_ph;
   logic [4:0]        r_edge, w_edge;
   logic [15:0]       r_shift, w_shift;
   logic              r_sclk, w_sclk;
   logic              r_sync_n, w_sync_n;
   logic              r_din, w_din;
   logic              r_ready, w_ready;
   logic              r_done, w_done;
   logic              w_tmr_load;
   logic [TMR_W-1:0]  w_tmr_val;
   logic              w_tmr_zero;

   dac121s101_interface_timer #(.W(TMR_W)) u_timer (
      .i_clk   (clk_i),
      .i_rst_n (rst_n_i),
      .i_load  (w_tmr_load),
      .i_val   (w_tmr_val),
      .o_zero  (w_tmr_zero)
   );

   // Next-state and next-output logic; every pin is registered from these.
   always_comb begin
      w_state    = r_state;
      w_ph       = r_ph;
      w_edge     = r_edge;
      w_shift    = r_shift;
      w_sclk     = r_sclk;
      w_sync_n   = r_sync_n;
      w_din      = r_din;
      w_ready    = 1'b0;
      w_done     = 1'b0;
      w_tmr_load = 1'b0;
      w_tmr_val  = '0;
      case (r_state)
         ST_IDLE: begin
            w_ready  = 1'b1;
            w_sync_n = 1'b1;
            w_sclk   = 1'b1;
            if (valid_i && r_ready) begin
               w_state    = ST_SETUP;
               w_ready    = 1'b0;
               w_sync_n   = 1'b0;
               w_shift    = {2'b00, mode_i, data_i};
               w_din      = w_shift[15];
               w_tmr_load = 1'b1;
               w_tmr_val  = TMR_W'(T_SU - 1);
            end
         end
         ST_SETUP: begin
            if (w_tmr_zero) begin
               w_state = ST_SHIFT;
               w_ph    = '0;
               w_edge  = '0;
               w_sclk  = 1'b1;
            end
         end
         ST_SHIFT: begin
            if (r_ph == PH_W'(CLK_DIV - 1)) begin
               if (r_edge == 5'(FRAME_BITS)) begin
                  w_state    = ST_QUIET;
                  w_sync_n   = 1'b1;
                  w_sclk     = 1'b1;
                  w_tmr_load = 1'b1;
                  w_tmr_val  = TMR_W'(T_QUIET - 1);
               end else begin
                  // New high phase: present the next bit well before its falling edge.
                  w_ph    = '0;
                  w_sclk  = 1'b1;
                  w_din   = r_shift[14];
                  w_shift = {r_shift[14:0], 1'b0};
               end
            end else begin
               w_ph = r_ph + 1'b1;
               if (w_ph == PH_W'(HIGH_PH)) begin
                  w_sclk = 1'b0;
                  w_edge = r_edge + 1'b1;
               end
            end
         end
         ST_QUIET: begin
            if (w_tmr_zero) begin
               w_state = ST_IDLE;
               w_ready = 1'b1;
               w_done  = 1'b1;
            end
         end
         default: w_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state  <= ST_IDLE;
         r_ph     <= '0;
         r_edge   <= '0;
         r_sclk   <= 1'b1;
         r_sync_n <= 1'b1;
         r_din    <= 1'b0;
         r_ready  <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_state  <= w_state;
         r_ph     <= w_ph;
         r_edge   <= w_edge;
         r_sclk   <= w_sclk;
         r_sync_n <= w_sync_n;
         r_din    <= w_din;
         r_ready  <= w_ready;
         r_done   <= w_done;
      end
   end

   always_ff @(posedge clk_i) begin
      r_shift <= w_shift;
   end

   assign ready_o  = r_ready;
   assign done_o   = r_done;
   assign sclk_o   = r_sclk;
   assign sync_n_o = r_sync_n;
   assign din_o    = r_din;

endmodule

// File: tb/tb_dac121s101_interface.sv
// Directed bench for dac121s101_interface at default clocking (T_SU=1, 2/3 SCLK, T_QUIET=2).
module tb_dac121s101_interface;

   logic        clk = 1'b0;
   logic        rst_n_i = 1'b0;
   logic [11:0] data_i = 12'h000;
   logic [1:0]  mode_i = 2'b00;
   logic        valid_i = 1'b0;
   logic        ready_o, done_o, sclk_o, sync_n_o, din_o;

   dac121s101_interface dut (
      .clk_i    (clk),
      .rst_n_i  (rst_n_i),
      .data_i   (data_i),
      .mode_i   (mode_i),
      .valid_i  (valid_i),
      .ready_o  (ready_o),
      .done_o   (done_o),
      .sclk_o   (sclk_o),
      .sync_n_o (sync_n_o),
      .din_o    (din_o)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;
   int cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Bits on falling SCLK while SYNC low; one record per SYNC rise.
   logic [15:0] cap = 16'h0000;
   int          falls_total = 0;
   int          falls_prev = 0;
   logic [15:0] fr_cap [0:15];
   int          fr_falls [0:15];
   int          nfr = 0;

   always @(negedge sclk_o) begin
      if (sync_n_o === 1'b0) begin
         cap = {cap[14:0], din_o};
         falls_total++;
      end
   end

   always @(posedge sync_n_o) begin
      fr_cap[nfr % 16]   = cap;
      fr_falls[nfr % 16] = falls_total - falls_prev;
      falls_prev = falls_total;
      nfr++;
   end

   int done_cyc [0:15];
   int ndone = 0;
   int lo_run = 0, hi_run = 0, last_low = 0, last_gap = 0;

   always @(posedge clk) begin
      #2;
      if (done_o === 1'b1) begin
         done_cyc[ndone % 16] = cyc;
         ndone++;
      end
      if (sync_n_o === 1'b0) begin
         if (hi_run > 0) last_gap = hi_run;
         hi_run = 0;
         lo_run++;
      end else begin
         if (lo_run > 0) last_low = lo_run;
         lo_run = 0;
         hi_run++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic send(input logic [11:0] d, input logic [1:0] m, output int h);
      int t;
      t = 0;
      while (ready_o !== 1'b1 && t < 300) begin
         @(negedge clk);
         t++;
      end
      chk("ready_wait", {31'd0, ready_o}, 32'd1);
      data_i  = d;
      mode_i  = m;
      valid_i = 1'b1;
      h = cyc;
      @(negedge clk);
      valid_i = 1'b0;
      data_i  = ~d;
      mode_i  = ~m;
   endtask

   task automatic wait_done(input int nd0);
      int t;
      t = 0;
      while (ndone <= nd0 && t < 400) begin
         @(negedge clk);
         t++;
      end
      chk("done_wait", (ndone > nd0) ? 32'd1 : 32'd0, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int h, h2, nd0, nf0, f0;

      // Reset held low while inputs toggle.
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         valid_i = i[0];
         data_i  = 12'hFFF ^ 12'(i);
         mode_i  = 2'(i);
      end
      chk("rst_sync", {31'd0, sync_n_o}, 32'd1);
      chk("rst_sclk", {31'd0, sclk_o}, 32'd1);
      chk("rst_din", {31'd0, din_o}, 32'd0);
      chk("rst_ready", {31'd0, ready_o}, 32'd0);
      chk("rst_done", {31'd0, done_o}, 32'd0);
      valid_i = 1'b0;
      rst_n_i = 1'b1;
      @(negedge clk);
      chk("ready_after_rst", {31'd0, ready_o}, 32'd1);
      repeat (3) @(negedge clk);

      // Single write, normal mode.
      nd0 = ndone; nf0 = nfr;
      send(12'hBA5, 2'b00, h);
      wait_done(nd0);
      chk("ba5_frame", {16'd0, fr_cap[nf0 % 16]}, 32'h0BA5);
      chk("ba5_falls", fr_falls[nf0 % 16], 16);
      chk("ba5_latency", done_cyc[nd0 % 16] - h, 84);
      chk("ba5_ready_at_done", {31'd0, ready_o}, 32'd1);
      repeat (4) @(negedge clk);

      // All-ones sample, high-impedance power-down.
      nd0 = ndone; nf0 = nfr;
      send(12'hFFF, 2'b11, h);
      wait_done(nd0);
      chk("fff_frame", {16'd0, fr_cap[nf0 % 16]}, 32'h3FFF);
      chk("fff_sync_low", last_low, 81);
      chk("fff_falls", fr_falls[nf0 % 16], 16);
      repeat (4) @(negedge clk);

      // Inputs change and valid pulses mid-frame.
      nd0 = ndone; nf0 = nfr;
      send(12'h5A5, 2'b01, h);
      repeat (20) @(negedge clk);
      data_i = 12'h000; mode_i = 2'b10; valid_i = 1'b1;
      @(negedge clk);
      valid_i = 1'b0; data_i = 12'hFFF;
      wait_done(nd0);
      repeat (10) @(negedge clk);
      chk("mid_frame", {16'd0, fr_cap[nf0 % 16]}, 32'h15A5);
      chk("mid_nframes", nfr - nf0, 1);
      chk("mid_ndone", ndone - nd0, 1);
      chk("mid_sync_idle", {31'd0, sync_n_o}, 32'd1);

      // Back-to-back with valid held high.
      nd0 = ndone; nf0 = nfr;
      data_i = 12'h123; mode_i = 2'b00; valid_i = 1'b1;
      h = cyc;
      @(negedge clk);
      data_i = 12'hABC;
      wait_done(nd0);
      h2 = cyc;
      @(negedge clk);
      valid_i = 1'b0; data_i = 12'h000;
      wait_done(nd0 + 1);
      chk("b2b_first", {16'd0, fr_cap[nf0 % 16]}, 32'h0123);
      chk("b2b_second", {16'd0, fr_cap[(nf0 + 1) % 16]}, 32'h0ABC);
      chk("b2b_lat1", done_cyc[nd0 % 16] - h, 84);
      chk("b2b_accept", h2 - done_cyc[nd0 % 16], 0);
      chk("b2b_done_gap", done_cyc[(nd0 + 1) % 16] - done_cyc[nd0 % 16], 84);
      chk("b2b_sync_gap", last_gap, 3);
      repeat (4) @(negedge clk);

      // Reset after 7 falling edges aborts the frame.
      nd0 = ndone; nf0 = nfr; f0 = falls_total;
      send(12'h0F0, 2'b00, h);
      for (int t = 0; t < 200 && (falls_total - f0) < 7; t++) @(negedge clk);
      chk("abort_falls_seen", falls_total - f0, 7);
      #3;
      rst_n_i = 1'b0;
      #1;
      chk("abort_sync", {31'd0, sync_n_o}, 32'd1);
      chk("abort_sclk", {31'd0, sclk_o}, 32'd1);
      chk("abort_ready", {31'd0, ready_o}, 32'd0);
      chk("abort_frame_falls", fr_falls[nf0 % 16], 7);
      repeat (3) @(negedge clk);
      rst_n_i = 1'b1;
      repeat (6) @(negedge clk);
      chk("abort_no_done", ndone - nd0, 0);

      // Clean write after the abort.
      nd0 = ndone; nf0 = nfr;
      send(12'h555, 2'b00, h);
      wait_done(nd0);
      chk("post_frame", {16'd0, fr_cap[nf0 % 16]}, 32'h0555);
      chk("post_falls", fr_falls[nf0 % 16], 16);
      chk("post_latency", done_cyc[nd0 % 16] - h, 84);
      chk("post_sync_low", last_low, 81);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
